// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding,
// grant-select codes and the default fetch-starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } arb_gnt_t;

    // Consecutive data grants tolerated while a fetch waits.
    localparam int DEF_STARVE_MAX = 4;

    // Counter width; covers the legal limit range 1..15.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants made while a fetch is waiting.
// at_max tells the arbiter to hand the next contested slot to fetch.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

    logic [STARVE_W-1:0] cnt;

    // Clear has priority; increment stops at the limit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, whatever the block order.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// access. Data has priority; a starvation counter forces fetch through
// after STARVE_MAX contested data grants. A flush while a fetch is in
// flight lets the memory access finish but swallows its valid pulse.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    // fetch side
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          flush,
    // data side
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_sb,
    input  logic          d_lb,
    input  logic          d_lbu,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    // memory side
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_sb,
    output logic          mem_lb,
    output logic          mem_lbu,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    arb_state_t state;
    arb_gnt_t   gnt;
    logic       kill;
    logic       starve_at_max;
    logic       d_elig;
    logic       i_elig;
    logic       starve_inc;
    logic       starve_clr;

    // A requester whose valid is pulsing this cycle is still holding its
    // old request, so it must not be granted again.
    assign d_elig = d_req && !d_valid;
    assign i_elig = if_req && !if_valid && !flush;

    // Pick a winner in IDLE: data first unless fetch has been starved.
    always_comb begin
        // NOTE: default assignment first so no path leaves gnt unassigned
        // and no latch is inferred.
        gnt = GNT_NONE;
        if (state == ST_IDLE) begin
            if (d_elig && !(i_elig && starve_at_max)) begin
                gnt = GNT_D;
            end else if (i_elig) begin
                gnt = GNT_IF;
            end
        end
    end

    assign starve_inc = (gnt == GNT_D) && if_req;
    assign starve_clr = (gnt == GNT_IF) || ((state == ST_IDLE) && !if_req);

    mem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    // Grant, hold the memory request until ack, then return data and pulse valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_sb    <= 1'b0;
            mem_lb    <= 1'b0;
            mem_lbu   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    kill <= 1'b0;
                    if (gnt == GNT_D) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_sb    <= d_sb;
                        mem_lb    <= d_lb;
                        mem_lbu   <= d_lbu;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= ST_BUSY_D;
                    end else if (gnt == GNT_IF) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_sb    <= 1'b0;
                        mem_lb    <= 1'b0;
                        mem_lbu   <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= ST_BUSY_I;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        // A redirect seen earlier or right now makes this word stale.
                        if_valid <= !(kill || flush);
                        kill     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        d_valid <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

endmodule
